// File: rtl/mips_cpu_muldiv_seq_if.sv
// Request/response bundle between the execute stage (master) and the HI/LO
// multiply/divide unit (slave).
interface mips_cpu_muldiv_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_cpu_muldiv_seq.sv
// Iterative 1-bit/cycle shift-add multiplier and restoring divider owning HI/LO.
// Optional MULDIV_EARLY_TERM_EN: zero operands skip the iteration phase.
module mips_cpu_muldiv_seq #(
  parameter int unsigned WIDTH = 32
) (
  input logic                    clk,
  input logic                    reset_n,
  mips_cpu_muldiv_seq_if.slave   bus
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StFix  = 2'd2;

  localparam logic [WIDTH-1:0] Zero = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] Ones = {WIDTH{1'b1}};

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift, div_trial;
  logic [2*WIDTH-1:0] div_step;
  logic [WIDTH-1:0]   quo, rem;

  // Signed ops run on magnitudes; signs are reapplied in StFix.
  assign a_mag = (bus.op[1] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.op[1] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, ma_q} : '0);
  assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}.
  // Comparison rather than borrow so a zero divisor still yields all-ones quotient.
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_trial = div_shift - {1'b0, mb_q};
  assign div_step  = (div_shift >= {1'b0, mb_q}) ?
                     {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1} :
                     {acc_q[2*WIDTH-2:0], 1'b0};

  assign quo = acc_q[WIDTH-1:0];
  assign rem = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            ma_d     = a_mag;
            mb_d     = b_mag;
            is_div_d = ~bus.op[0];
            neg_d    = bus.op[1] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            rneg_d   = bus.op[1] & bus.a[WIDTH-1];
            acc_d    = bus.op[0] ? {Zero, b_mag} : {Zero, a_mag};
            count_d  = '0;
            state_d  = StCalc;
`ifdef MULDIV_EARLY_TERM_EN
            if (a_mag == Zero || b_mag == Zero) begin
              acc_d   = bus.op[0] ? {Zero, Zero} : {a_mag, (b_mag == Zero) ? Ones : Zero};
              state_d = StFix;
            end
`endif
          end else if (!bus.op[1]) begin
            if (bus.op[0]) lo_d = bus.a;
            else           hi_d = bus.a;
            done_d = 1'b1;
          end
        end
      end
      StCalc: begin
        acc_d   = is_div_q ? div_step : mul_step;
        count_d = count_q + CntW'(1);
        if (count_q == CntLast) state_d = StFix;
      end
      StFix: begin
        if (is_div_q) begin
          // A zero divisor leaves the all-ones quotient un-negated.
          lo_d = (neg_q && mb_q != Zero) ? -quo : quo;
          hi_d = rneg_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      acc_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_seq.sv
// Directed bench for mips_cpu_muldiv_seq: latency, busy/done protocol, HI/LO results,
// MTHI/MTLO, ignored starts, reset abort and back-to-back issue.
module tb_mips_cpu_muldiv_seq;

  localparam int W = 32;
`ifdef MULDIV_EARLY_TERM_EN
  localparam int ZLat = 2;
`else
  localparam int ZLat = 34;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_hi, exp_lo;

  mips_cpu_muldiv_seq_if #(.WIDTH(W)) bus ();

  mips_cpu_muldiv_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue in the current cycle, wait for done, check protocol and results.
  // poke > 0 drives an MTHI request during that in-flight cycle, which must be ignored.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int exp_lat,
                        input logic [W-1:0] e_hi, input logic [W-1:0] e_lo, input int poke);
    int   lat;
    logic busy_bad, hold_bad;
    bus.start = 1'b1;
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    tick();
    bus.start = 1'b0;
    lat      = 1;
    busy_bad = 1'b0;
    hold_bad = 1'b0;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_bad = 1'b1;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) hold_bad = 1'b1;
      if (lat == poke) begin
        bus.start = 1'b1;
        bus.op    = 3'b100;
        bus.a     = 32'hA5A5_A5A5;
      end
      tick();
      bus.start = 1'b0;
      lat++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy in flight"}, {31'd0, busy_bad}, 32'd0);
    chk({tag, " busy at done"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " hi/lo hold"}, {31'd0, hold_bad}, 32'd0);
    chk({tag, " hi"}, bus.hi, e_hi);
    chk({tag, " lo"}, bus.lo, e_lo);
    exp_hi = e_hi;
    exp_lo = e_lo;
  endtask

  initial begin
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'b111;
    bus.a     = '0;
    bus.b     = '0;
    exp_hi    = '0;
    exp_lo    = '0;
    tick();
    tick();
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    reset_n = 1'b1;
    tick();

    run_op("multu max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
           32'hFFFF_FFFE, 32'h0000_0001, 0);
    tick();
    chk("done single pulse", {31'd0, bus.done}, 32'd0);

    run_op("mult -3*7", 3'b011, 32'hFFFF_FFFD, 32'h0000_0007, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    tick();
    run_op("div -7/2", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 34,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    tick();
    run_op("div 7/-2", 3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 34,
           32'h0000_0001, 32'hFFFF_FFFD, 0);
    tick();
    run_op("divu by zero", 3'b000, 32'h0000_0064, 32'h0000_0000, ZLat,
           32'h0000_0064, 32'hFFFF_FFFF, 0);
    tick();
    run_op("div neg by zero", 3'b010, 32'hFFFF_FFF9, 32'h0000_0000, ZLat,
           32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);
    tick();
    run_op("div overflow", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 34,
           32'h0000_0000, 32'h8000_0000, 0);
    tick();
    run_op("mult max*min", 3'b011, 32'h7FFF_FFFF, 32'h8000_0000, 34,
           32'hC000_0000, 32'h8000_0000, 0);
    tick();
    run_op("divu ffffffff/16", 3'b000, 32'hFFFF_FFFF, 32'h0000_0010, 34,
           32'h0000_000F, 32'h0FFF_FFFF, 0);
    tick();
    run_op("multu zero", 3'b001, 32'h0000_0000, 32'h0000_0005, ZLat,
           32'h0000_0000, 32'h0000_0000, 0);
    tick();

    run_op("mthi idle", 3'b100, 32'h1234_5678, 32'h0, 1, 32'h1234_5678, exp_lo, 0);
    tick();
    run_op("mtlo idle", 3'b101, 32'hCAFE_F00D, 32'h0, 1, exp_hi, 32'hCAFE_F00D, 0);
    tick();
    run_op("multu 3*4 + mthi busy", 3'b001, 32'h3, 32'h4, 34, 32'h0, 32'hC, 5);

    // op 11x: no effect, no done
    tick();
    bus.start = 1'b1;
    bus.op    = 3'b110;
    bus.a     = 32'hDEAD_BEEF;
    tick();
    bus.start = 1'b0;
    chk("op 11x done", {31'd0, bus.done}, 32'd0);
    chk("op 11x busy", {31'd0, bus.busy}, 32'd0);
    chk("op 11x hi", bus.hi, exp_hi);
    chk("op 11x lo", bus.lo, exp_lo);

    // Reset asserted mid-multiply aborts it and clears HI/LO.
    bus.start = 1'b1;
    bus.op    = 3'b001;
    bus.a     = 32'd5;
    bus.b     = 32'd6;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    reset_n = 1'b0;
    tick();
    chk("abort busy", {31'd0, bus.busy}, 32'd0);
    chk("abort done", {31'd0, bus.done}, 32'd0);
    chk("abort hi", bus.hi, 32'd0);
    chk("abort lo", bus.lo, 32'd0);
    reset_n = 1'b1;
    tick();
    chk("abort no done", {31'd0, bus.done}, 32'd0);
    exp_hi = '0;
    exp_lo = '0;
    run_op("divu 7/2", 3'b000, 32'd7, 32'd2, 34, 32'd1, 32'd3, 0);

    // Issued in the done cycle of the previous op.
    run_op("b2b multu", 3'b001, 32'h0001_0000, 32'h0001_0000, 34, 32'd1, 32'd0, 0);
    run_op("b2b divu", 3'b000, 32'd100, 32'd7, 34, 32'd2, 32'd14, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
